layer_link_fifo: RTL and testbench

//  Elastic stream buffer between a conv layer's m_data_out_y/m_valid_y/m_ready_y port and the next layer's s_data_in_x port.

---
 rtl/layer_link_pkg.sv | 9 +
 rtl/fifo_regfile.sv | 18 +
 rtl/layer_link_fifo.sv | 69 ++++++
 tb/tb_layer_link_fifo.sv | 125 ++++++++++++
 4 files changed

// File: rtl/layer_link_pkg.sv
// layer_link_pkg: shared word type, ReLU helper and default frame length for the layer link FIFO
package layer_link_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int DEFAULT_FRAME_LEN = 32;
  typedef logic signed [WORD_WIDTH-1:0] word_t;
  function automatic word_t relu(input word_t x);
    return x[WORD_WIDTH-1] ? '0 : x;
  endfunction
endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: DEPTH x WIDTH storage, one synchronous write port and one asynchronous read port
module fifo_regfile #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int LOGDEPTH = 5
) (
  input  logic                clk,
  input  logic                we,
  input  logic [LOGDEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [LOGDEPTH-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/layer_link_fifo.sv
// layer_link_fifo: elastic buffer between conv layers with per-frame last tagging
// Optional ReLU on ingress when LAYER_LINK_RELU_EN is defined.
module layer_link_fifo
  import layer_link_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int LOGDEPTH  = 5,
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int LOGFRAME  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    s_data_in,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [WIDTH-1:0]    m_data_out,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic [LOGDEPTH:0]   count
);
  localparam logic [LOGDEPTH:0]   FULL = (LOGDEPTH+1)'(DEPTH);
  localparam logic [LOGFRAME-1:0] LAST = LOGFRAME'(FRAME_LEN-1);
  logic [LOGDEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOGDEPTH:0]   count_q, count_d;
  logic [LOGFRAME-1:0] fcnt_q, fcnt_d;
  logic                push, pop;
  logic [WIDTH-1:0]    wdata;
`ifdef LAYER_LINK_RELU_EN
  assign wdata = s_data_in[WIDTH-1] ? '0 : s_data_in;
`else
  assign wdata = s_data_in;
`endif
  // Ready depends only on registered count, so a pop never opens ready in the same cycle.
  assign s_ready = !reset && (count_q != FULL);
  assign m_valid = count_q != '0;
  assign m_last  = m_valid && (fcnt_q == LAST);
  assign count   = count_q;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    fcnt_d   = !pop ? fcnt_q : (fcnt_q == LAST) ? '0 : fcnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fcnt_q   <= fcnt_d;
    end
  end
  fifo_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOGDEPTH(LOGDEPTH)) u_regfile (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (m_data_out)
  );
endmodule

// File: tb/tb_layer_link_fifo.sv
// tb_layer_link_fifo: directed and random stimulus checked against a queue-based reference model
module tb_layer_link_fifo;
  localparam int DEPTH = 32;
  localparam int FRAME = 32;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data_in;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data_out;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [5:0]  count;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] q[$];
  int          pops = 0;
  always #5 clk = ~clk;
  layer_link_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .s_data_in  (s_data_in),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data_out (m_data_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .count      (count)
  );
  function automatic logic [15:0] f(input logic [15:0] x);
`ifdef LAYER_LINK_RELU_EN
    return x[15] ? 16'd0 : x;
`else
    return x;
`endif
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] d, input logic r, input logic rst);
    logic ex_push, ex_pop;
    s_valid = v; s_data_in = d; m_ready = r; reset = rst;
    #1;
    check("s_ready", 32'(s_ready), 32'(!rst && q.size() < DEPTH));
    check("m_valid", 32'(m_valid), 32'(q.size() > 0));
    check("count", 32'(count), 32'(q.size()));
    check("m_last", 32'(m_last), 32'(q.size() > 0 && pops == FRAME-1));
    if (q.size() > 0) check("m_data", 32'(m_data_out), 32'(q[0]));
    @(posedge clk);
    ex_push = v && !rst && q.size() < DEPTH;
    ex_pop  = r && !rst && q.size() > 0;
    if (rst) begin
      q.delete();
      pops = 0;
    end else begin
      if (ex_pop) begin
        void'(q.pop_front());
        pops = (pops + 1) % FRAME;
      end
      if (ex_push) q.push_back(f(d));
    end
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      n++;
    end
  endtask
  initial begin
    int i;
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data_in = '0;
    @(posedge clk); @(posedge clk); #1;
    step(1'b1, 16'h0009, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'd5, 1'b0, 1'b0);
    step(1'b1, 16'hFFFD, 1'b0, 1'b0);
    step(1'b1, 16'd7, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    drain();
    for (i = 0; i < DEPTH; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    drain();
    step(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (i = 0; i < 40; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
    drain();
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (i = 0; i < 64; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    drain();
    step(1'b0, 16'h0, 1'b0, 1'b1);
    i = 0;
    while (i < 64) begin
      logic acc;
      acc = q.size() < DEPTH;
      step(1'b1, 16'(i), 1'($urandom_range(0, 1)), 1'b0);
      if (acc) i++;
    end
    drain();
    for (i = 0; i < 10; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (i = 0; i < 32; i++) begin
      step(1'b1, 16'($urandom), 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    for (i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 299) == 0));
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
